fx3_slave_writer: RTL and testbench
===================================

# fx3_slave_writer

Downstream consumer of the three-stage prefetch FIFO output: pops 32-bit words from the top stage and drives the Cypress FX3 GPIF-II synchronous slave-FIFO write bus. Tracks DMA buffer fill, waits for FX3 buffer readiness, and closes short packets with PKTEND on idle timeout or explicit flush. Runs entirely in the 100 MHz data clock domain.

## Interface
- BUF_WORDS, 4096: FX3 DMA buffer size in 32-bit words; a full buffer auto-commits.
- WM_WORDS, 6: words remaining in the buffer when FX3 drives watermark flagb_i low.
- FLAG_LAT, 3: cycles after a commit before fx3_flaga_i is trusted again.
- IDLE_TIMEOUT, 1024: consecutive no-data cycles in a partial buffer before PKTEND.
- SOCKET, 2'b00: GPIF socket address driven on fx3_addr_o.
- data_clk  in  1  clock; one clock for the whole block.
- data_rstn  in  1  reset, asynchronous assert, active-low.
- data_i  in  32  top-stage data word.
- data_valid_top_i  in  1  data_i valid.
- data_read_o  out  1  pop strobe for the top stage; combinational, one word per cycle.
- flush_i  in  1  single-cycle request to commit the current partial buffer.
- fx3_data_o  out  32  slave-FIFO data bus, registered.
- fx3_addr_o  out  2  socket address, registered.
- fx3_slcs_n_o, fx3_slwr_n_o, fx3_pktend_n_o, fx3_sloe_n_o, fx3_slrd_n_o  out  1 each  active-low strobes, registered.
- fx3_flaga_i  in  1  1 = current socket buffer ready for writes.
- fx3_flagb_i  in  1  watermark, 0 = at most WM_WORDS words left.
- words_sent_o  out  32  total words written; wraps at 2^32.
- error_o  out  1  sticky protocol error; cleared only by reset.

## Operation
- States: IDLE, WRITE, PKTEND, COMMIT_WAIT.
- IDLE: data_read_o=0. If fx3_flaga_i=1, go to WRITE.
- WRITE: data_read_o = data_valid_top_i. Each pop increments buf_cnt (width clog2(BUF_WORDS)+1) and words_sent_o, and clears the idle counter.
- WRITE, pop with buf_cnt = BUF_WORDS-1: last word. Go to COMMIT_WAIT; buf_cnt <= 0.
- WRITE, flush_i=1 or idle counter reaches IDLE_TIMEOUT-1, with buf_cnt>0: go to PKTEND with no pop that cycle. The pop is suppressed even if data is valid.
- flush_i or timeout with buf_cnt=0: ignored; no zero-length packet.
- PKTEND: one cycle; fx3_pktend_n_o=0, fx3_slwr_n_o=1; buf_cnt <= 0; go to COMMIT_WAIT.
- COMMIT_WAIT: hold for FLAG_LAT cycles, then go to IDLE.
- Error, sets error_o:
  - fx3_flagb_i=0 while buf_cnt < BUF_WORDS-WM_WORDS.
  - fx3_flaga_i=0 in WRITE with buf_cnt>0.
  - In both cases writing continues.
- Fixed strobes: fx3_sloe_n_o=1 and fx3_slrd_n_o=1 always (write-only). fx3_addr_o=SOCKET. fx3_slcs_n_o=0 from the first cycle after reset release.

## Timing
- Reset values: data_read_o=0, fx3_data_o=0, fx3_addr_o=SOCKET; slcs_n, slwr_n, pktend_n, sloe_n, slrd_n all 1; words_sent_o=0, error_o=0; state IDLE.
- Pop in cycle N: fx3_data_o=data_i and fx3_slwr_n_o=0 in cycle N+1. Back-to-back pops give continuous slwr_n low.
- The PKTEND pulse is registered and appears one cycle after the PKTEND decision cycle. It never overlaps slwr_n low.
- flush_i in the same cycle as the last-word pop: the full commit wins and flush_i is discarded.
- Idle counter saturates; it counts only in WRITE with buf_cnt>0.
- Reset assertion mid-burst: all outputs go to reset values immediately and asynchronously; the partial FX3 buffer is abandoned.

## Structure
- Shared package fx3_pkg:
  - State enum.
  - SOCKET default.
  - Strobe inactive level constant.
  - BUF_WORDS, WM_WORDS and FLAG_LAT defaults.
- One natural sub-module, fx3_idle_timer: saturating counter with clear and enable; emits a timeout pulse at IDLE_TIMEOUT-1.

## Test plan
- Reset, flaga=1, 4096 continuous valid words 0..4095:
  - 4096 slwr_n-low cycles, data 0..4095, no pktend.
  - COMMIT_WAIT lasts 3 cycles; words_sent_o=4096.
- 10 words, then valid low:
  - pktend_n pulse exactly 1024 cycles after the last pop decision.
  - Next word starts a new buffer (buf_cnt=0).
- flush_i after 5 words:
  - pktend_n one cycle later.
  - flush_i with buf_cnt=0: no pktend.
- flaga=0 after reset, valid high: data_read_o stays 0. Raise flaga: first slwr_n low two cycles later.
- flagb_i=0 at buf_cnt=100: error_o=1 and sticky; writing continues.
- Reset asserted mid-burst: all strobes return to 1 combinationally; words_sent_o=0.

Source files
------------

// File: rtl/fx3_pkg.sv
// Shared definitions for the FX3 slave-FIFO write path.
//   fx3_state_e      : writer FSM states
//   SOCKET_DEF       : default GPIF socket address
//   STROBE_OFF       : inactive level of the active-low FX3 strobes
//   *_DEF            : default buffer size, watermark, flag latency, idle timeout
package fx3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WRITE       = 2'd1,
    ST_PKTEND      = 2'd2,
    ST_COMMIT_WAIT = 2'd3
  } fx3_state_e;

  localparam logic [1:0]  SOCKET_DEF       = 2'b00;
  localparam logic        STROBE_OFF       = 1'b1;
  localparam int unsigned BUF_WORDS_DEF    = 4096;
  localparam int unsigned WM_WORDS_DEF     = 6;
  localparam int unsigned FLAG_LAT_DEF     = 3;
  localparam int unsigned IDLE_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/fx3_idle_timer.sv
// Saturating idle-cycle counter.
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the count (data present or not in a partial buffer)
//   en         : count this cycle
//   timeout    : pulse on the cycle the idle run reaches IDLE_TIMEOUT-1
module fx3_idle_timer
  import fx3_pkg::*;
#(
  parameter int unsigned IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  localparam int unsigned CW = $clog2(IDLE_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(IDLE_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(IDLE_TIMEOUT - 2);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (en && cnt != CNT_MAX) cnt <= cnt + 1'b1;
  end

  // The current idle cycle is part of the run, so the run length reaches
  // IDLE_TIMEOUT-1 while the register still holds IDLE_TIMEOUT-2.
  assign timeout = en & ~clr & (cnt == CNT_PRE);

endmodule

// File: rtl/fx3_slave_writer.sv
// Pops words from the prefetch FIFO top stage and writes them to the FX3
// GPIF-II synchronous slave FIFO. Full buffers auto-commit; partial buffers
// are closed with PKTEND on flush or idle timeout.
//   data_clk, data_rstn     : clock, async active-low reset
//   data_i/data_valid_top_i : top-stage word and its valid
//   data_read_o             : combinational pop strobe
//   flush_i                 : commit the current partial buffer
//   fx3_*_o                 : registered slave-FIFO bus and strobes
//   fx3_flaga_i/flagb_i     : buffer ready / watermark flags
//   words_sent_o, error_o   : total words written, sticky protocol error
module fx3_slave_writer
  import fx3_pkg::*;
#(
  parameter int unsigned BUF_WORDS    = BUF_WORDS_DEF,
  parameter int unsigned WM_WORDS     = WM_WORDS_DEF,
  parameter int unsigned FLAG_LAT     = FLAG_LAT_DEF,
  parameter int unsigned IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
  parameter logic [1:0]  SOCKET       = SOCKET_DEF
) (
  input  logic        data_clk,
  input  logic        data_rstn,
  input  logic [31:0] data_i,
  input  logic        data_valid_top_i,
  output logic        data_read_o,
  input  logic        flush_i,
  output logic [31:0] fx3_data_o,
  output logic [1:0]  fx3_addr_o,
  output logic        fx3_slcs_n_o,
  output logic        fx3_slwr_n_o,
  output logic        fx3_pktend_n_o,
  output logic        fx3_sloe_n_o,
  output logic        fx3_slrd_n_o,
  input  logic        fx3_flaga_i,
  input  logic        fx3_flagb_i,
  output logic [31:0] words_sent_o,
  output logic        error_o
);
  localparam int unsigned BW = $clog2(BUF_WORDS) + 1;
  localparam int unsigned LW = (FLAG_LAT > 1) ? $clog2(FLAG_LAT) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(BUF_WORDS - 1);
  localparam logic [BW-1:0] WM_LIMIT = BW'(BUF_WORDS - WM_WORDS);
  localparam logic [LW-1:0] LAT_END  = LW'(FLAG_LAT - 1);

  fx3_state_e    state, state_nxt;
  logic [BW-1:0] buf_cnt;
  logic [LW-1:0] lat_cnt;
  logic          pop, close, last_pop, idle_en, idle_clr, timeout, flag_err;

  assign idle_en  = (state == ST_WRITE) && (buf_cnt != '0);
  assign idle_clr = ~idle_en | data_valid_top_i;

  fx3_idle_timer #(.IDLE_TIMEOUT(IDLE_TIMEOUT)) u_idle_timer (
    .clk    (data_clk),
    .rst_n  (data_rstn),
    .clr    (idle_clr),
    .en     (idle_en),
    .timeout(timeout)
  );

  // state register
  always_ff @(posedge data_clk or negedge data_rstn) begin
    if (!data_rstn) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:        if (fx3_flaga_i) state_nxt = ST_WRITE;
      ST_WRITE:       if (close)         state_nxt = ST_PKTEND;
                      else if (last_pop) state_nxt = ST_COMMIT_WAIT;
      ST_PKTEND:      state_nxt = ST_COMMIT_WAIT;
      ST_COMMIT_WAIT: if (lat_cnt == LAT_END) state_nxt = ST_IDLE;
      default:        state_nxt = ST_IDLE;
    endcase
  end

  // outputs: a last-word pop outranks flush/timeout, so a full buffer never
  // gets a trailing PKTEND; otherwise closing suppresses the pop.
  always_comb begin
    close    = 1'b0;
    pop      = 1'b0;
    last_pop = 1'b0;
    if (state == ST_WRITE) begin
      close    = (flush_i | timeout) & (buf_cnt != '0) &
                 ~(data_valid_top_i & (buf_cnt == LAST_IDX));
      pop      = data_valid_top_i & ~close;
      last_pop = pop & (buf_cnt == LAST_IDX);
    end
  end

  assign data_read_o = pop;

  assign flag_err = (~fx3_flagb_i & (buf_cnt < WM_LIMIT)) |
                    ((state == ST_WRITE) & ~fx3_flaga_i & (buf_cnt != '0));

  always_ff @(posedge data_clk or negedge data_rstn) begin
    if (!data_rstn) begin
      buf_cnt        <= '0;
      lat_cnt        <= '0;
      words_sent_o   <= '0;
      error_o        <= 1'b0;
      fx3_data_o     <= '0;
      fx3_addr_o     <= SOCKET;
      fx3_slcs_n_o   <= STROBE_OFF;
      fx3_slwr_n_o   <= STROBE_OFF;
      fx3_pktend_n_o <= STROBE_OFF;
      fx3_sloe_n_o   <= STROBE_OFF;
      fx3_slrd_n_o   <= STROBE_OFF;
    end else begin
      lat_cnt <= (state == ST_COMMIT_WAIT) ? lat_cnt + 1'b1 : '0;
      // cleared at the close decision so the PKTEND cycle already sees an
      // empty buffer
      if (close || last_pop) buf_cnt <= '0;
      else if (pop)          buf_cnt <= buf_cnt + 1'b1;
      if (pop) begin
        words_sent_o <= words_sent_o + 32'd1;
        fx3_data_o   <= data_i;
      end
      if (flag_err) error_o <= 1'b1;
      fx3_slwr_n_o   <= ~pop;
      fx3_pktend_n_o <= ~close;
      fx3_slcs_n_o   <= 1'b0;
      fx3_addr_o     <= SOCKET;
      fx3_sloe_n_o   <= STROBE_OFF;
      fx3_slrd_n_o   <= STROBE_OFF;
    end
  end

endmodule

// File: tb/tb_fx3_slave_writer.sv
module tb_fx3_slave_writer;
  localparam int BUF = 4096, WM = 6, LAT = 3, TMO = 1024;

  logic        data_clk = 1'b0, data_rstn = 1'b0;
  logic [31:0] data_i = '0;
  logic        data_valid_top_i = 1'b0, flush_i = 1'b0;
  logic        fx3_flaga_i = 1'b1, fx3_flagb_i = 1'b1;
  logic        data_read_o, fx3_slcs_n_o, fx3_slwr_n_o, fx3_pktend_n_o;
  logic        fx3_sloe_n_o, fx3_slrd_n_o, error_o;
  logic [31:0] fx3_data_o, words_sent_o;
  logic [1:0]  fx3_addr_o;

  fx3_slave_writer dut (
    .data_clk(data_clk), .data_rstn(data_rstn), .data_i(data_i),
    .data_valid_top_i(data_valid_top_i), .data_read_o(data_read_o),
    .flush_i(flush_i), .fx3_data_o(fx3_data_o), .fx3_addr_o(fx3_addr_o),
    .fx3_slcs_n_o(fx3_slcs_n_o), .fx3_slwr_n_o(fx3_slwr_n_o),
    .fx3_pktend_n_o(fx3_pktend_n_o), .fx3_sloe_n_o(fx3_sloe_n_o),
    .fx3_slrd_n_o(fx3_slrd_n_o), .fx3_flaga_i(fx3_flaga_i),
    .fx3_flagb_i(fx3_flagb_i), .words_sent_o(words_sent_o), .error_o(error_o)
  );

  always #5 data_clk = ~data_clk;

  int tb_cyc = 0;
  always @(posedge data_clk) tb_cyc <= tb_cyc + 1;

  int n_chk = 0, n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, tb_cyc);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  // Writer is either "active" (may pop) or blocked until m_resume, when it
  // starts polling flaga again. Outputs for the next cycle are predicted
  // from this cycle's pop / close decision.
  bit          m_active, m_slwr_n, m_pktend_n, m_slcs_n, m_err;
  int          m_resume, m_cyc, m_fill, m_idle;
  logic [31:0] m_sent, m_data;
  int          slwr_cnt = 0, pktend_cnt = 0, pktend_cyc = 0, last_pop_cyc = 0, last_slwr_cyc = 0;

  task automatic model_reset();
    m_active = 0; m_resume = 0; m_cyc = 0; m_fill = 0; m_idle = 0;
    m_sent = 0; m_data = 0; m_slwr_n = 1; m_pktend_n = 1; m_slcs_n = 1; m_err = 0;
  endtask

  initial begin
    bit e_pop, e_close, e_last, e_tmo;
    int run;
    model_reset();
    forever begin
      @(negedge data_clk);
      if (!data_rstn) begin
        model_reset();
        check("rst_slwr_n", fx3_slwr_n_o, 1);
        check("rst_pktend_n", fx3_pktend_n_o, 1);
        check("rst_words", words_sent_o, 0);
        check("rst_read", data_read_o, 0);
      end else begin
        check("slwr_n", fx3_slwr_n_o, m_slwr_n);
        check("pktend_n", fx3_pktend_n_o, m_pktend_n);
        check("fx3_data", fx3_data_o, m_data);
        check("words_sent", words_sent_o, m_sent);
        check("error", error_o, m_err);
        check("slcs_n", fx3_slcs_n_o, m_slcs_n);
        check("addr", fx3_addr_o, 0);
        check("sloe_slrd", {fx3_sloe_n_o, fx3_slrd_n_o}, 3);
        if (!fx3_pktend_n_o) check("pktend_vs_slwr", fx3_slwr_n_o, 1);

        e_pop = 0; e_close = 0;
        if (m_active) begin
          run     = data_valid_top_i ? 0 : m_idle + 1;
          e_tmo   = (m_fill > 0) && !data_valid_top_i && (run == TMO - 1);
          e_last  = data_valid_top_i && (m_fill == BUF - 1);
          e_close = (flush_i || e_tmo) && (m_fill > 0) && !e_last;
          e_pop   = data_valid_top_i && !e_close;
        end
        check("data_read", data_read_o, e_pop);

        if ((!fx3_flagb_i && m_fill < BUF - WM) || (m_active && m_fill > 0 && !fx3_flaga_i))
          m_err = 1;
        if (m_active && m_fill > 0 && !data_valid_top_i) m_idle = (m_idle < TMO - 1) ? m_idle + 1 : m_idle;
        else m_idle = 0;
        m_slwr_n = !e_pop; m_pktend_n = !e_close; m_slcs_n = 0;
        if (e_pop) begin m_data = data_i; m_sent++; m_fill++; end
        if (e_close) begin m_active = 0; m_fill = 0; m_resume = m_cyc + 2 + LAT; end
        else if (e_pop && m_fill == BUF) begin m_active = 0; m_fill = 0; m_resume = m_cyc + 1 + LAT; end
        else if (!m_active && m_cyc >= m_resume && fx3_flaga_i) m_active = 1;
        m_cyc++;

        if (!fx3_slwr_n_o) begin slwr_cnt++; last_slwr_cyc = tb_cyc; end
        if (!fx3_pktend_n_o) begin pktend_cnt++; pktend_cyc = tb_cyc; end
        if (data_read_o) last_pop_cyc = tb_cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  bit popped;
  int word = 0, pops = 0;

  // one cycle; emulates the FIFO top stage advancing on a pop
  task automatic tick();
    @(negedge data_clk);
    popped = data_read_o;
    @(posedge data_clk);
    #1;
    if (popped) begin word++; pops++; end
    data_i = 32'(word);
  endtask

  task automatic feed(input int n, input int budget);
    int got, spent;
    got = 0; spent = 0;
    data_valid_top_i = 1;
    while (got < n && spent < budget) begin
      tick(); spent++;
      if (popped) got++;
    end
    check("feed_count", got, n);
  endtask

  task automatic wait_pktend(input string nm, input int budget);
    int n0, spent;
    n0 = pktend_cnt; spent = 0;
    while (pktend_cnt == n0 && spent < budget) begin tick(); spent++; end
    check(nm, pktend_cnt - n0, 1);
  endtask

  initial begin
    int p_last, fc, n0, rc, s0, spent;
    repeat (3) tick();
    check("rst_slcs_n", fx3_slcs_n_o, 1);
    check("rst_error", error_o, 0);
    check("rst_data", fx3_data_o, 0);
    check("rst_addr", fx3_addr_o, 0);
    data_rstn = 1;

    // full buffer, words 0..4095, then one more word after the commit
    feed(BUF, 5000);
    check("words_4096", words_sent_o, 4096);
    check("last_word", fx3_data_o, 4095);
    check("full_no_pktend", pktend_cnt, 0);
    p_last = last_pop_cyc;
    feed(1, 20);
    check("commit_gap", last_pop_cyc - p_last, 5);
    check("slwr_lows_4096", slwr_cnt, 4096);

    // 10 words in the new buffer, then idle until timeout
    feed(9, 20);
    data_valid_top_i = 0;
    wait_pktend("timeout_pktend", 1200);
    check("timeout_dist", pktend_cyc - last_pop_cyc, 1024);
    check("words_4106", words_sent_o, 4106);

    // 5 words then flush with data still valid
    feed(5, 20);
    flush_i = 1; fc = tb_cyc;
    tick();
    flush_i = 0; data_valid_top_i = 0;
    check("flush_pop_suppressed", popped, 0);
    wait_pktend("flush_pktend", 5);
    check("flush_dist", pktend_cyc - fc, 1);

    // flush on an empty buffer
    repeat (8) tick();
    n0 = pktend_cnt;
    flush_i = 1; tick(); flush_i = 0;
    repeat (6) tick();
    check("no_zlp", pktend_cnt, n0);

    // flaga low after reset
    data_rstn = 0; fx3_flaga_i = 0; data_valid_top_i = 1;
    repeat (2) tick();
    data_rstn = 1; pops = 0;
    repeat (10) tick();
    check("noflaga_no_pop", pops, 0);
    fx3_flaga_i = 1; rc = tb_cyc; s0 = slwr_cnt; spent = 0;
    while (slwr_cnt == s0 && spent < 10) begin tick(); spent++; end
    check("flaga_to_slwr", last_slwr_cyc - rc, 2);

    // watermark violation at buf_cnt = 100
    feed(100 - pops, 200);
    check("err_before", error_o, 0);
    fx3_flagb_i = 0; tick(); fx3_flagb_i = 1;
    check("err_set", error_o, 1);
    check("wr_continues", popped, 1);
    repeat (5) tick();
    check("err_sticky", error_o, 1);
    check("burst_active", fx3_slwr_n_o, 0);

    // asynchronous reset mid-burst
    #2 data_rstn = 0;
    #1;
    check("arst_slwr_n", fx3_slwr_n_o, 1);
    check("arst_pktend_n", fx3_pktend_n_o, 1);
    check("arst_slcs_n", fx3_slcs_n_o, 1);
    check("arst_words", words_sent_o, 0);
    check("arst_error", error_o, 0);
    check("arst_read", data_read_o, 0);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
